// File: rtl/spi_master_byte_xfer.sv
// SPI master byte engine (CPHA=0, MSB first): one 8-bit frame per accepted i_start; done 19*CLK_CNT_HALF cycles after accept.
// No backpressure: i_start is only looked at in IDLE and is ignored while a frame is in flight.
module spi_master_byte_xfer #(
    parameter int   CLK_CNT_HALF       = 10,
    parameter int   CLK_CNT_HALF_WIDTH = 4,
    parameter logic CPOL               = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       im_MISO,
    output logic       om_SCLK_spi,
    output logic       om_CS_n,
    output logic       om_MOSI,
    output logic       om_launch_edge,
    output logic       om_sample_edge,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rx_byte
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_LAG,
        ST_GAP
    } state_t;

    localparam logic [CLK_CNT_HALF_WIDTH-1:0] HALF_LAST = CLK_CNT_HALF_WIDTH'(CLK_CNT_HALF - 1);
    localparam logic [CLK_CNT_HALF_WIDTH-1:0] HALF_ONE  = CLK_CNT_HALF_WIDTH'(1);

    state_t                        state_q, state_d;
    logic [CLK_CNT_HALF_WIDTH-1:0] half_cnt_q, half_cnt_d;
    logic [3:0]                    edge_cnt_q, edge_cnt_d;
    logic [7:0]                    tx_q, tx_d;
    logic [7:0]                    rx_q, rx_d;
    logic                          sclk_q, sclk_d;
    logic                          cs_n_q, cs_n_d;
    logic                          mosi_q, mosi_d;
    logic                          launch_q, launch_d;
    logic                          sample_q, sample_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [7:0]                    rx_byte_q, rx_byte_d;
    logic                          half_last;

    assign half_last = (half_cnt_q == HALF_LAST);

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        launch_d   = 1'b0;
        sample_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_byte_d  = rx_byte_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = CPOL;
                if (i_start) begin
                    tx_d       = i_tx_byte;
                    cs_n_d     = 1'b0;
                    mosi_d     = i_tx_byte[7];
                    busy_d     = 1'b1;
                    half_cnt_d = '0;
                    edge_cnt_d = '0;
                    state_d    = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    state_d    = ST_SHIFT;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_ONE;
                end
            end
            ST_SHIFT: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (!edge_cnt_q[0]) begin
                        // Leading edge: capture MISO.
                        rx_d     = {rx_q[6:0], im_MISO};
                        sample_d = 1'b1;
                    end else begin
                        // Trailing edge: present the next bit; the last one only closes the frame.
                        launch_d = 1'b1;
                        if (edge_cnt_q == 4'd15) begin
                            state_d = ST_LAG;
                        end else begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_ONE;
                end
            end
            ST_LAG: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    state_d    = ST_GAP;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_ONE;
                end
            end
            ST_GAP: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    done_d     = 1'b1;
                    rx_byte_d  = rx_q;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sclk_q     <= CPOL;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            launch_q   <= 1'b0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            launch_q   <= launch_d;
            sample_q   <= sample_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign om_SCLK_spi    = sclk_q;
    assign om_CS_n        = cs_n_q;
    assign om_MOSI        = mosi_q;
    assign om_launch_edge = launch_q;
    assign om_sample_edge = sample_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_rx_byte      = rx_byte_q;

endmodule

// File: tb/tb_spi_master_byte_xfer.sv
// Bench for spi_master_byte_xfer: a CPOL=0 and a CPOL=1 instance share stimulus and are checked
// cycle by cycle against a frame timeline computed from the half-period count.
module tb_spi_master_byte_xfer;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_tx_byte;
    logic       im_miso;

    logic       sclk0, cs_n0, mosi0, launch0, sample0, busy0, done0;
    logic [7:0] rx0;
    logic       sclk1, cs_n1, mosi1, launch1, sample1, busy1, done1;
    logic [7:0] rx1;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         cs_rise_cyc = -1000;
    bit         loop_mode = 1'b0;
    logic [7:0] slave_byte = 8'h00;
    logic [7:0] slv_sr = 8'h00;
    logic [7:0] exp_rx = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: first bit valid while CS_n is low, advances on every master launch pulse.
    always @(negedge clk) begin
        if (cs_n0) slv_sr <= slave_byte;
        else if (launch0) slv_sr <= {slv_sr[6:0], 1'b0};
    end
    assign im_miso = loop_mode ? mosi0 : slv_sr[7];

    spi_master_byte_xfer #(.CLK_CNT_HALF(H), .CLK_CNT_HALF_WIDTH(4), .CPOL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_tx_byte(i_tx_byte), .im_MISO(im_miso),
        .om_SCLK_spi(sclk0), .om_CS_n(cs_n0), .om_MOSI(mosi0), .om_launch_edge(launch0),
        .om_sample_edge(sample0), .o_busy(busy0), .o_done(done0), .o_rx_byte(rx0));

    spi_master_byte_xfer #(.CLK_CNT_HALF(H), .CLK_CNT_HALF_WIDTH(4), .CPOL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_tx_byte(i_tx_byte), .im_MISO(im_miso),
        .om_SCLK_spi(sclk1), .om_CS_n(cs_n1), .om_MOSI(mosi1), .om_launch_edge(launch1),
        .om_sample_edge(sample1), .o_busy(busy1), .o_done(done1), .o_rx_byte(rx1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int m);
        int bad;
        bad = 0;
        for (int i = 0; i < m; i++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || cs_n0 !== 1'b1 ||
                sclk0 !== 1'b0 || sclk1 !== 1'b1 || launch0 !== 1'b0 || sample0 !== 1'b0 ||
                rx0 !== exp_rx) bad++;
        end
        chk("idle_quiet", bad, 0);
    endtask

    // Caller has raised i_start with i_tx_byte=tx just after a negedge while the DUT is idle.
    // Returns at the negedge of the done cycle with i_start low, or after a mid-frame reset.
    task automatic run_frame(input logic [7:0] tx, input logic [7:0] slv, input bit loop,
                             input bit poke, input int abort_n);
        int bad_sclk0, bad_sclk1, bad_cs, bad_mosi, bad_smp, bad_lch, bad_busy, bad_rx, bad_done;
        int rises, done_n, nbits, ph, j, bad_rst;
        bit aborted, shifting, e_act, e_edge, e_smp, e_lch;
        logic e_cs, e_mosi, e_busy, e_done, prev_sclk;
        logic [7:0] exp_new, e_rx, mosi_bits;
        bad_sclk0 = 0; bad_sclk1 = 0; bad_cs = 0; bad_mosi = 0; bad_smp = 0;
        bad_lch = 0; bad_busy = 0; bad_rx = 0; bad_done = 0; bad_rst = 0;
        rises = 0; done_n = -1; nbits = 0; aborted = 1'b0; prev_sclk = 1'b0; mosi_bits = 8'h00;
        slave_byte = slv;
        loop_mode = loop;
        exp_new = loop ? tx : slv;
        @(posedge clk);
        for (int n = 0; n <= 19 * H + 20; n++) begin
            @(negedge clk);
            shifting = (n >= 2 * H) && (n < 18 * H);
            ph       = shifting ? (n - 2 * H) / H : 0;
            e_act    = shifting && (ph % 2 == 0);
            e_edge   = shifting && ((n - 2 * H) % H == 0);
            e_smp    = e_edge && (ph % 2 == 0);
            e_lch    = e_edge && (ph % 2 == 1);
            e_cs     = (n >= 18 * H);
            j        = (n < 3 * H) ? 0 : ((n - 3 * H) / (2 * H) + 1);
            if (j > 7) j = 7;
            e_mosi   = (n < 18 * H) ? tx[7 - j] : 1'b0;
            e_busy   = (n < 19 * H);
            e_done   = (n == 19 * H);
            e_rx     = (n >= 19 * H) ? exp_new : exp_rx;
            if (sclk0 !== e_act) bad_sclk0++;
            if (sclk1 !== ~e_act) bad_sclk1++;
            if (cs_n0 !== e_cs || cs_n1 !== e_cs) bad_cs++;
            if (mosi0 !== e_mosi) bad_mosi++;
            if (sample0 !== e_smp) bad_smp++;
            if (launch0 !== e_lch) bad_lch++;
            if (busy0 !== e_busy) bad_busy++;
            if (done0 !== e_done || done1 !== e_done) bad_done++;
            if (rx0 !== e_rx || rx1 !== e_rx) bad_rx++;
            if (n == 0) chk("cs_high_gap_ge_H", ((cyc - cs_rise_cyc) >= H), 1);
            if (n == 18 * H) cs_rise_cyc = cyc;
            if (sample0 === 1'b1) begin
                mosi_bits = {mosi_bits[6:0], mosi0};
                nbits++;
            end
            if (sclk0 === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = sclk0;
            if (n == abort_n) begin
                rst_n = 1'b0;
                #1;
                chk("abort_cs_n", cs_n0, 1);
                chk("abort_sclk_cpol0", sclk0, 0);
                chk("abort_sclk_cpol1", sclk1, 1);
                chk("abort_busy_mosi", {busy0, mosi0, launch0, sample0}, 0);
                exp_rx = 8'h00;
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    if (done0 !== 1'b0 || rx0 !== 8'h00 || cs_n0 !== 1'b1) bad_rst++;
                end
                rst_n = 1'b1;
                cs_rise_cyc = cyc;
                chk("abort_no_done", bad_rst, 0);
                aborted = 1'b1;
                break;
            end
            i_start = poke && (n == 59 || n == 174);
            if (poke) i_tx_byte = 8'($urandom);
            if (done0 === 1'b1) begin
                done_n = n;
                break;
            end
        end
        i_start = 1'b0;
        chk("sclk_cpol0_shape", bad_sclk0, 0);
        chk("sclk_cpol1_shape", bad_sclk1, 0);
        chk("cs_n_shape", bad_cs, 0);
        chk("mosi_timeline", bad_mosi, 0);
        chk("sample_on_leading", bad_smp, 0);
        chk("launch_on_trailing", bad_lch, 0);
        chk("busy_window", bad_busy, 0);
        chk("done_pulse", bad_done, 0);
        chk("rx_hold_update", bad_rx, 0);
        if (!aborted) begin
            chk("done_latency", done_n, 19 * H);
            chk("sclk_pulses", rises, 8);
            chk("mosi_bits_msb_first", {nbits[7:0], mosi_bits}, {8'd8, tx});
            chk("rx_byte", rx0, exp_new);
            exp_rx = exp_new;
        end
    endtask

    task automatic start(input logic [7:0] tx);
        i_start   = 1'b1;
        i_tx_byte = tx;
    endtask

    initial begin
        logic [7:0] t, s;
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sclk", {sclk0, sclk1}, 2'b01);
        chk("rst_cs_n", {cs_n0, cs_n1}, 2'b11);
        chk("rst_busy_done", {busy0, done0, mosi0, launch0, sample0}, 0);
        chk("rst_rx_byte", rx0, 8'h00);
        rst_n = 1'b1;
        idle(H + 2);

        // Loopback, fixed byte
        start(8'hA5);
        run_frame(8'hA5, 8'h00, 1'b1, 1'b0, -1);
        idle(20);

        // Slave returns its own byte
        start(8'hFF);
        run_frame(8'hFF, 8'h3C, 1'b0, 1'b0, -1);
        idle(20);

        // Mid-frame start pulses and tx changes are ignored
        t = 8'($urandom); s = 8'($urandom);
        start(t);
        run_frame(t, s, 1'b0, 1'b1, -1);
        idle(3 * H);

        // Back-to-back: next start raised in the done cycle
        t = 8'($urandom); s = 8'($urandom);
        start(t);
        run_frame(t, s, 1'b0, 1'b0, -1);
        start(8'h5A);
        run_frame(8'h5A, 8'h00, 1'b1, 1'b0, -1);
        idle(20);

        // Reset on the 5th SCLK edge, then a clean frame
        t = 8'($urandom);
        start(t);
        run_frame(t, 8'h00, 1'b1, 1'b0, 6 * H);
        idle(2 * H);
        t = 8'($urandom); s = 8'($urandom);
        start(t);
        run_frame(t, s, 1'b0, 1'b0, -1);
        idle(10);

        for (int f = 0; f < 4; f++) begin
            t = 8'($urandom); s = 8'($urandom);
            start(t);
            run_frame(t, s, f[0], 1'b0, -1);
            idle(5 + f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
